// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter of the multi-cycle MIPS core.
// Holds the FSM state encoding, the port IDs and the round-robin pick function.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  // On a tie the port that did not win last time gets the grant.
  function automatic logic rr_pick(input logic i_req, input logic d_req, input logic last);
    logic pick;
    if (i_req && d_req) begin
      pick = ~last;
    end else if (d_req) begin
      pick = PORT_D;
    end else begin
      pick = PORT_I;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one word memory port between instruction fetch
// and data load/store, with WAIT_CYCLES extra access cycles and a one-cycle ack per request.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             owner;
  logic             last_grant;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic             any_req;
  logic             pick;
  logic             last_cycle;

  assign any_req    = i_req | d_req;
  assign pick       = rr_pick(i_req, d_req, last_grant);
  assign last_cycle = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_read  = ~lat_we;
        // A store strobes only once, in the final access cycle.
        mem_write = lat_we & last_cycle;
        if (last_cycle) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        i_ack     = (owner == PORT_I);
        d_ack     = (owner == PORT_D);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      owner      <= PORT_I;
      last_grant <= PORT_I;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner     <= pick;
            lat_addr  <= (pick == PORT_D) ? d_addr : i_addr;
            lat_wdata <= (pick == PORT_D) ? d_wdata : 32'd0;
            lat_we    <= (pick == PORT_D) & d_we;
            cnt       <= WAIT_LOAD;
          end
        end
        ST_ACCESS: begin
          if (!last_cycle) begin
            cnt <= cnt - 1'b1;
          end else begin
            last_grant <= owner;
            if (!lat_we) begin
              if (owner == PORT_D) begin
                d_rdata <= mem_rdata;
              end else begin
                i_rdata <= mem_rdata;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a W=0 instance driven by a cycle table plus reset checks,
// and a W=2 instance exercised with hand-written load, store and abort sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // W=0 instance signals
  logic        rst0;
  logic        i_req0, d_req0, d_we0;
  logic [31:0] i_addr0, d_addr0, d_wdata0;
  logic [31:0] i_rdata0, d_rdata0;
  logic        i_ack0, d_ack0;
  logic        mem_read0, mem_write0;
  logic [31:0] mem_addr0, mem_wdata0, mem_rdata0;

  // W=2 instance signals
  logic        rst2;
  logic        i_req2, d_req2, d_we2;
  logic [31:0] i_addr2, d_addr2, d_wdata2;
  logic [31:0] i_rdata2, d_rdata2;
  logic        i_ack2, d_ack2;
  logic        mem_read2, mem_write2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2;

  logic [7:0] mem0 [0:255];
  logic [7:0] mem2 [0:255];

  assign mem_rdata0 = {mem0[mem_addr0[7:0]], mem0[mem_addr0[7:0] + 8'd1],
                       mem0[mem_addr0[7:0] + 8'd2], mem0[mem_addr0[7:0] + 8'd3]};
  assign mem_rdata2 = {mem2[mem_addr2[7:0]], mem2[mem_addr2[7:0] + 8'd1],
                       mem2[mem_addr2[7:0] + 8'd2], mem2[mem_addr2[7:0] + 8'd3]};

  mem_arbiter #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0),
    .i_req(i_req0), .i_addr(i_addr0), .i_rdata(i_rdata0), .i_ack(i_ack0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_rdata(d_rdata0), .d_ack(d_ack0),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
  );

  mem_arbiter #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst2),
    .i_req(i_req2), .i_addr(i_addr2), .i_rdata(i_rdata2), .i_ack(i_ack2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_rdata(d_rdata2), .d_ack(d_ack2),
    .mem_read(mem_read2), .mem_write(mem_write2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  typedef struct {
    logic        ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, dwdata;
    logic        e_rd, e_wr, e_iack, e_dack;
    logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
  } vec_t;

  vec_t vq[$];

  int wr2_cnt  = 0;
  int dack2_cnt = 0;
  int iack2_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance one clock; the memory models commit a write seen in the ending cycle.
  task automatic tick();
    logic        w0, w2;
    logic [7:0]  a0, a2;
    logic [31:0] wd0, wd2;
    w0 = mem_write0; a0 = mem_addr0[7:0]; wd0 = mem_wdata0;
    w2 = mem_write2; a2 = mem_addr2[7:0]; wd2 = mem_wdata2;
    if (mem_write2) wr2_cnt++;
    if (d_ack2) dack2_cnt++;
    if (i_ack2) iack2_cnt++;
    @(posedge clk);
    if (w0) begin
      mem0[a0] = wd0[31:24]; mem0[a0 + 8'd1] = wd0[23:16];
      mem0[a0 + 8'd2] = wd0[15:8]; mem0[a0 + 8'd3] = wd0[7:0];
    end
    if (w2) begin
      mem2[a2] = wd2[31:24]; mem2[a2 + 8'd1] = wd2[23:16];
      mem2[a2 + 8'd2] = wd2[15:8]; mem2[a2 + 8'd3] = wd2[7:0];
    end
    #1;
  endtask

  localparam logic [31:0] P = 32'h8C010004;
  localparam logic [31:0] B = 32'hDEADBEEF;
  localparam logic [31:0] L = 32'h11223344;

  initial begin
    logic [31:0] word;
    rst0 = 1'b1; rst2 = 1'b1;
    i_req0 = 1'b1; d_req0 = 1'b1; d_we0 = 1'b0;
    i_addr0 = 32'h10; d_addr0 = 32'h30; d_wdata0 = 32'h0;
    i_req2 = 1'b0; d_req2 = 1'b0; d_we2 = 1'b0;
    i_addr2 = 32'h0; d_addr2 = 32'h0; d_wdata2 = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem2[i] = 8'h00;
    end
    mem0[8'h10] = 8'h8C; mem0[8'h11] = 8'h01; mem0[8'h12] = 8'h00; mem0[8'h13] = 8'h04;
    mem0[8'h30] = 8'h11; mem0[8'h31] = 8'h22; mem0[8'h32] = 8'h33; mem0[8'h33] = 8'h44;
    mem2[8'h40] = 8'hA1; mem2[8'h41] = 8'hB2; mem2[8'h42] = 8'hC3; mem2[8'h43] = 8'hD4;
    mem2[8'h48] = 8'hCA; mem2[8'h49] = 8'hFE; mem2[8'h4A] = 8'hF0; mem2[8'h4B] = 8'h0D;

    // Reset held with both requests active: everything stays quiet.
    tick(); tick();
    @(negedge clk);
    chk("rst mem_read", {31'd0, mem_read0}, 32'd0);
    chk("rst mem_write", {31'd0, mem_write0}, 32'd0);
    chk("rst acks", {30'd0, i_ack0, d_ack0}, 32'd0);
    chk("rst mem_addr", mem_addr0, 32'd0);
    chk("rst i_rdata", i_rdata0, 32'd0);
    chk("rst d_rdata", d_rdata0, 32'd0);
    tick();
    i_req0 = 1'b0; d_req0 = 1'b0;
    rst0 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    chk("post-rst idle read", {31'd0, mem_read0}, 32'd0);
    tick();
    @(negedge clk);
    chk("post-rst idle read2", {31'd0, mem_read0}, 32'd0);
    tick();

    //        ireq dreq dwe  iaddr  daddr  dwdata  rd   wr   iack dack addr   wdata  irdata drdata
    vq.push_back('{1'b1,1'b0,1'b0,32'h10,32'h0, 32'h0, 1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0, 32'h0, 32'h0});
    vq.push_back('{1'b1,1'b0,1'b0,32'h10,32'h0, 32'h0, 1'b1,1'b0,1'b0,1'b0,32'h10,32'h0, 32'h0, 32'h0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0, 32'h0, 32'h0, 1'b0,1'b0,1'b1,1'b0,32'h0, 32'h0, P,     32'h0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0, 32'h0, 32'h0, 1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0, P,     32'h0});
    vq.push_back('{1'b0,1'b1,1'b1,32'h0, 32'h20,B,     1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0, P,     32'h0});
    vq.push_back('{1'b0,1'b1,1'b1,32'h0, 32'h20,B,     1'b0,1'b1,1'b0,1'b0,32'h20,B,     P,     32'h0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0, 32'h0, 32'h0, 1'b0,1'b0,1'b0,1'b1,32'h0, 32'h0, P,     32'h0});
    vq.push_back('{1'b1,1'b0,1'b0,32'h20,32'h0, 32'h0, 1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0, P,     32'h0});
    vq.push_back('{1'b1,1'b0,1'b0,32'h20,32'h0, 32'h0, 1'b1,1'b0,1'b0,1'b0,32'h20,32'h0, P,     32'h0});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0, 32'h0, 32'h0, 1'b0,1'b0,1'b1,1'b0,32'h0, 32'h0, B,     32'h0});
    // Both ports held: data wins the first tie, then strict alternation.
    vq.push_back('{1'b1,1'b1,1'b0,32'h10,32'h30,32'h0, 1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0, B,     32'h0});
    vq.push_back('{1'b1,1'b1,1'b0,32'h10,32'h30,32'h0, 1'b1,1'b0,1'b0,1'b0,32'h30,32'h0, B,     32'h0});
    vq.push_back('{1'b1,1'b1,1'b0,32'h10,32'h30,32'h0, 1'b0,1'b0,1'b0,1'b1,32'h0, 32'h0, B,     L});
    vq.push_back('{1'b1,1'b1,1'b0,32'h10,32'h30,32'h0, 1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0, B,     L});
    vq.push_back('{1'b1,1'b1,1'b0,32'h10,32'h30,32'h0, 1'b1,1'b0,1'b0,1'b0,32'h10,32'h0, B,     L});
    vq.push_back('{1'b1,1'b1,1'b0,32'h10,32'h30,32'h0, 1'b0,1'b0,1'b1,1'b0,32'h0, 32'h0, P,     L});
    vq.push_back('{1'b1,1'b1,1'b0,32'h10,32'h30,32'h0, 1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0, P,     L});
    vq.push_back('{1'b1,1'b1,1'b0,32'h10,32'h30,32'h0, 1'b1,1'b0,1'b0,1'b0,32'h30,32'h0, P,     L});
    vq.push_back('{1'b1,1'b1,1'b0,32'h10,32'h30,32'h0, 1'b0,1'b0,1'b0,1'b1,32'h0, 32'h0, P,     L});
    vq.push_back('{1'b1,1'b1,1'b0,32'h10,32'h30,32'h0, 1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0, P,     L});
    vq.push_back('{1'b1,1'b1,1'b0,32'h10,32'h30,32'h0, 1'b1,1'b0,1'b0,1'b0,32'h10,32'h0, P,     L});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0, 32'h0, 32'h0, 1'b0,1'b0,1'b1,1'b0,32'h0, 32'h0, P,     L});
    vq.push_back('{1'b0,1'b0,1'b0,32'h0, 32'h0, 32'h0, 1'b0,1'b0,1'b0,1'b0,32'h0, 32'h0, P,     L});

    foreach (vq[k]) begin
      i_req0 = vq[k].ireq; d_req0 = vq[k].dreq; d_we0 = vq[k].dwe;
      i_addr0 = vq[k].iaddr; d_addr0 = vq[k].daddr; d_wdata0 = vq[k].dwdata;
      @(negedge clk);
      chk($sformatf("row%0d mem_read", k), {31'd0, mem_read0}, {31'd0, vq[k].e_rd});
      chk($sformatf("row%0d mem_write", k), {31'd0, mem_write0}, {31'd0, vq[k].e_wr});
      chk($sformatf("row%0d i_ack", k), {31'd0, i_ack0}, {31'd0, vq[k].e_iack});
      chk($sformatf("row%0d d_ack", k), {31'd0, d_ack0}, {31'd0, vq[k].e_dack});
      chk($sformatf("row%0d mem_addr", k), mem_addr0, vq[k].e_addr);
      chk($sformatf("row%0d mem_wdata", k), mem_wdata0, vq[k].e_wdata);
      chk($sformatf("row%0d i_rdata", k), i_rdata0, vq[k].e_irdata);
      chk($sformatf("row%0d d_rdata", k), d_rdata0, vq[k].e_drdata);
      tick();
    end

    // Asynchronous reset in the middle of an access clears outputs without a clock edge.
    i_req0 = 1'b1; d_req0 = 1'b1; d_we0 = 1'b0; i_addr0 = 32'h10; d_addr0 = 32'h30;
    tick();
    #2;
    chk("pre-async mem_read", {31'd0, mem_read0}, 32'd1);
    rst0 = 1'b1;
    #1;
    chk("async mem_read", {31'd0, mem_read0}, 32'd0);
    chk("async mem_addr", mem_addr0, 32'd0);
    chk("async i_rdata", i_rdata0, 32'd0);
    chk("async d_rdata", d_rdata0, 32'd0);
    chk("async acks", {30'd0, i_ack0, d_ack0}, 32'd0);
    tick(); tick();
    @(negedge clk);
    chk("rst held read", {31'd0, mem_read0}, 32'd0);
    tick();
    i_req0 = 1'b0; d_req0 = 1'b0;
    rst0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d read", c), {31'd0, mem_read0}, 32'd0);
      chk($sformatf("idle%0d acks", c), {30'd0, i_ack0, d_ack0}, 32'd0);
      tick();
    end

    // W=2 load from 0x40: read in cycles 1..3, ack in cycle 4.
    d_we2 = 1'b0; d_addr2 = 32'h40; d_wdata2 = 32'h0;
    for (int k = 0; k < 6; k++) begin
      d_req2 = (k < 4);
      @(negedge clk);
      chk($sformatf("w2 load c%0d read", k), {31'd0, mem_read2}, {31'd0, (k >= 1 && k <= 3)});
      chk($sformatf("w2 load c%0d d_ack", k), {31'd0, d_ack2}, {31'd0, (k == 4)});
      chk($sformatf("w2 load c%0d i_ack", k), {31'd0, i_ack2}, 32'd0);
      if (k == 4) chk("w2 load d_rdata", d_rdata2, 32'hA1B2C3D4);
      tick();
    end

    // W=2 store to 0x44: one write strobe, only in cycle 3.
    wr2_cnt = 0;
    d_we2 = 1'b1; d_addr2 = 32'h44; d_wdata2 = 32'h55AA55AA;
    for (int k = 0; k < 6; k++) begin
      d_req2 = (k < 4);
      @(negedge clk);
      chk($sformatf("w2 store c%0d write", k), {31'd0, mem_write2}, {31'd0, (k == 3)});
      chk($sformatf("w2 store c%0d read", k), {31'd0, mem_read2}, 32'd0);
      chk($sformatf("w2 store c%0d d_ack", k), {31'd0, d_ack2}, {31'd0, (k == 4)});
      if (k == 3) chk("w2 store addr", mem_addr2, 32'h44);
      tick();
    end
    chk("w2 store count", wr2_cnt, 32'd1);
    word = {mem2[8'h44], mem2[8'h45], mem2[8'h46], mem2[8'h47]};
    chk("w2 store mem", word, 32'h55AA55AA);
    chk("w2 store keeps d_rdata", d_rdata2, 32'hA1B2C3D4);

    // Reset during cycle 1 of a W=2 store aborts it: no write, no ack.
    wr2_cnt = 0; dack2_cnt = 0; iack2_cnt = 0;
    d_req2 = 1'b1; d_we2 = 1'b1; d_addr2 = 32'h48; d_wdata2 = 32'h12345678;
    tick();
    rst2 = 1'b1;
    #1;
    chk("abort write now", {31'd0, mem_write2}, 32'd0);
    d_req2 = 1'b0;
    tick(); tick();
    rst2 = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("abort write count", wr2_cnt, 32'd0);
    chk("abort ack count", dack2_cnt + iack2_cnt, 32'd0);
    word = {mem2[8'h48], mem2[8'h49], mem2[8'h4A], mem2[8'h4B]};
    chk("abort mem", word, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
